// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one 16-bit-word memory between two byte-addressed requesters.
//   Port A is the CPU data side and port B is the loader/debug port.
//   Each byte address is converted to a word address plus a byte lane.
//   The memory only writes whole words, so a byte write is done as a
//   read-modify-write: read the word, merge the new byte, write it back.
//
// Ports
//   clk, rst_n            clock (rising edge), synchronous active-low reset
//   x_req/we/word/addr/   per-port request (x = a | b); the request is held
//   x_wdata                 until x_ack; byte writes use wdata[7:0]
//   x_ack                 one-cycle completion pulse
//   x_rdata               read data; held until the next read on that port
//   mem_addr/we/wdata     word address, write enable and write word to the
//                           memory macro; the write commits on the clock edge
//   mem_rdata             combinational read word for mem_addr
module mem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_we,
    input  logic              a_word,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [15:0]       a_wdata,
    output logic              a_ack,
    output logic [15:0]       a_rdata,
    input  logic              b_req,
    input  logic              b_we,
    input  logic              b_word,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [15:0]       b_wdata,
    output logic              b_ack,
    output logic [15:0]       b_rdata,
    output logic [ADDR_W-2:0] mem_addr,
    output logic              mem_we,
    output logic [15:0]       mem_wdata,
    input  logic [15:0]       mem_rdata
);

    typedef enum logic [1:0] {IDLE, ACCESS, WRITE} state_t;

    state_t            state_q, state_d;
    logic              own_q, own_d;       // 0 = port A, 1 = port B
    logic              last_q, last_d;     // port granted most recently
    logic              we_q, we_d;
    logic              word_q, word_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [15:0]       wdata_q, wdata_d;
    logic [15:0]       merge_q, merge_d;
    logic              a_ack_q, a_ack_d;
    logic              b_ack_q, b_ack_d;
    logic [15:0]       a_rdata_q, a_rdata_d;
    logic [15:0]       b_rdata_q, b_rdata_d;

    logic              a_elig, b_elig, grant_b, done;
    logic [15:0]       rd_val;
    logic [ADDR_W-2:0] mem_addr_c;
    logic              mem_we_c;
    logic [15:0]       mem_wdata_c;

    always_comb begin
        state_d     = state_q;
        own_d       = own_q;
        last_d      = last_q;
        we_d        = we_q;
        word_d      = word_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        merge_d     = merge_q;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        mem_addr_c  = '0;
        mem_we_c    = 1'b0;
        mem_wdata_c = '0;
        done        = 1'b0;
        // A port in its ack cycle still shows req high; ignoring it there
        // keeps the same request from being served twice.
        a_elig      = a_req & ~a_ack_q;
        b_elig      = b_req & ~b_ack_q;
        // Under contention, pick the port that was not granted last.
        grant_b     = b_elig & (~a_elig | ~last_q);
        rd_val      = word_q ? mem_rdata
                             : {8'h00, addr_q[0] ? mem_rdata[15:8] : mem_rdata[7:0]};

        case (state_q)
            IDLE: begin
                if (a_elig || b_elig) begin
                    own_d   = grant_b;
                    last_d  = grant_b;
                    we_d    = grant_b ? b_we    : a_we;
                    word_d  = grant_b ? b_word  : a_word;
                    addr_d  = grant_b ? b_addr  : a_addr;
                    wdata_d = grant_b ? b_wdata : a_wdata;
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                mem_addr_c = addr_q[ADDR_W-1:1];
                if (!we_q) begin
                    if (own_q) b_rdata_d = rd_val;
                    else       a_rdata_d = rd_val;
                    done    = 1'b1;
                    state_d = IDLE;
                end else if (word_q) begin
                    mem_we_c    = 1'b1;
                    mem_wdata_c = wdata_q;
                    done        = 1'b1;
                    state_d     = IDLE;
                end else begin
                    // First half of the byte write: capture the current word.
                    merge_d = mem_rdata;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                mem_addr_c  = addr_q[ADDR_W-1:1];
                mem_we_c    = 1'b1;
                mem_wdata_c = addr_q[0] ? {wdata_q[7:0], merge_q[7:0]}
                                        : {merge_q[15:8], wdata_q[7:0]};
                done        = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        a_ack_d = done & ~own_q;
        b_ack_d = done &  own_q;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            own_q     <= 1'b0;
            last_q    <= 1'b1;   // B counts as last granted, so A wins first
            we_q      <= 1'b0;
            word_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            merge_q   <= '0;
            a_ack_q   <= 1'b0;
            b_ack_q   <= 1'b0;
            a_rdata_q <= '0;
            b_rdata_q <= '0;
        end else begin
            state_q   <= state_d;
            own_q     <= own_d;
            last_q    <= last_d;
            we_q      <= we_d;
            word_q    <= word_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            merge_q   <= merge_d;
            a_ack_q   <= a_ack_d;
            b_ack_q   <= b_ack_d;
            a_rdata_q <= a_rdata_d;
            b_rdata_q <= b_rdata_d;
        end
    end

    // A write must never reach the memory while reset is held, even if the
    // FSM is still in a write state during the first reset cycle.
    assign mem_we    = mem_we_c & rst_n;
    assign mem_addr  = mem_addr_c;
    assign mem_wdata = mem_wdata_c;
    assign a_ack     = a_ack_q;
    assign b_ack     = b_ack_q;
    assign a_rdata   = a_rdata_q;
    assign b_rdata   = b_rdata_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a behavioural 128 x 16 memory.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        a_req, a_we, a_word, b_req, b_we, b_word;
    logic [7:0]  a_addr, b_addr;
    logic [15:0] a_wdata, b_wdata;
    logic        a_ack, b_ack;
    logic [15:0] a_rdata, b_rdata;
    logic [6:0]  mem_addr;
    logic        mem_we;
    logic [15:0] mem_wdata, mem_rdata;

    logic [15:0] mem [128];
    logic        pl_we = 1'b0;
    logic [6:0]  pl_addr;
    logic [15:0] pl_data;
    int          we_cnt = 0;
    int          pass_cnt = 0;
    int          tot_cnt = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.ADDR_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_we(a_we), .a_word(a_word), .a_addr(a_addr),
        .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
        .b_req(b_req), .b_we(b_we), .b_word(b_word), .b_addr(b_addr),
        .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    assign mem_rdata = mem[mem_addr];

    always @(posedge clk) begin
        if (mem_we) begin
            mem[mem_addr] <= mem_wdata;
            we_cnt <= we_cnt + 1;
        end
        if (pl_we) mem[pl_addr] <= pl_data;
    end

    // All tasks start and end just after a falling edge.
    task automatic poke(input logic [6:0] a, input logic [15:0] d);
        pl_addr = a; pl_data = d; pl_we = 1'b1;
        @(negedge clk);
        pl_we = 1'b0;
    endtask

    task automatic start_a(input logic we, input logic word, input logic [7:0] ad, input logic [15:0] wd);
        a_we = we; a_word = word; a_addr = ad; a_wdata = wd; a_req = 1'b1;
    endtask

    task automatic start_b(input logic we, input logic word, input logic [7:0] ad, input logic [15:0] wd);
        b_we = we; b_word = word; b_addr = ad; b_wdata = wd; b_req = 1'b1;
    endtask

    // Cycles until the selected ack is seen; 99 on timeout.
    task automatic wait_ack(input logic is_b, output int lat);
        lat = 99;
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if ((is_b ? b_ack : a_ack) === 1'b1) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset;
        int lat;
        rst_n = 1'b0;
        start_a(1'b0, 1'b1, 8'h10, 16'h0);
        repeat (2) begin
            @(negedge clk);
            tot_cnt++; if (a_ack !== 1'b0) $display("FAIL rst_a_ack: got %b exp 0", a_ack); else pass_cnt++;
            tot_cnt++; if (mem_we !== 1'b0) $display("FAIL rst_mem_we: got %b exp 0", mem_we); else pass_cnt++;
            tot_cnt++; if (mem_addr !== 7'h00) $display("FAIL rst_mem_addr: got %h exp 00", mem_addr); else pass_cnt++;
        end
        tot_cnt++; if (a_rdata !== 16'h0 || b_rdata !== 16'h0 || b_ack !== 1'b0)
            $display("FAIL rst_outputs: got a_rdata %h b_rdata %h b_ack %b exp 0 0 0", a_rdata, b_rdata, b_ack);
        else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        tot_cnt++; if (mem_addr !== 7'h08) $display("FAIL rst_first_addr: got %h exp 08", mem_addr); else pass_cnt++;
        wait_ack(1'b0, lat);
        a_req = 1'b0;
        tot_cnt++; if (lat !== 1) $display("FAIL rst_first_lat: got %0d exp 1 after cycle 1", lat); else pass_cnt++;
        tot_cnt++; if (a_rdata !== 16'hC0DE) $display("FAIL rst_first_rdata: got %h exp c0de", a_rdata); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_read;
        int lat;
        start_a(1'b0, 1'b1, 8'h0A, 16'h0);
        wait_ack(1'b0, lat);
        a_req = 1'b0;
        tot_cnt++; if (lat !== 2) $display("FAIL word_read_lat: got %0d exp 2", lat); else pass_cnt++;
        tot_cnt++; if (a_rdata !== 16'hBEEF) $display("FAIL word_read_data: got %h exp beef", a_rdata); else pass_cnt++;
        @(negedge clk);
        tot_cnt++; if (a_rdata !== 16'hBEEF) $display("FAIL rdata_hold: got %h exp beef", a_rdata); else pass_cnt++;
        start_a(1'b0, 1'b0, 8'h0B, 16'h0);
        wait_ack(1'b0, lat);
        a_req = 1'b0;
        tot_cnt++; if (a_rdata !== 16'h00BE) $display("FAIL byte_read_hi: got %h exp 00be", a_rdata); else pass_cnt++;
        @(negedge clk);
        start_a(1'b0, 1'b0, 8'h0A, 16'h0);
        wait_ack(1'b0, lat);
        a_req = 1'b0;
        tot_cnt++; if (a_rdata !== 16'h00EF) $display("FAIL byte_read_lo: got %h exp 00ef", a_rdata); else pass_cnt++;
        @(negedge clk);
        // Word 7'h7F, high lane, via byte address FF.
        start_a(1'b0, 1'b0, 8'hFF, 16'h0);
        wait_ack(1'b0, lat);
        a_req = 1'b0;
        tot_cnt++; if (a_rdata !== 16'h0077) $display("FAIL byte_read_ff: got %h exp 0077", a_rdata); else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_byte_write;
        int lat;
        start_b(1'b1, 1'b0, 8'h07, 16'h00AB);
        @(negedge clk);
        tot_cnt++; if (mem_we !== 1'b0 || mem_addr !== 7'h03)
            $display("FAIL bw_cycle1: got we %b addr %h exp 0 03", mem_we, mem_addr);
        else pass_cnt++;
        @(negedge clk);
        tot_cnt++; if (mem_we !== 1'b1 || mem_wdata !== 16'hAB34 || mem_addr !== 7'h03)
            $display("FAIL bw_cycle2: got we %b wdata %h addr %h exp 1 ab34 03", mem_we, mem_wdata, mem_addr);
        else pass_cnt++;
        wait_ack(1'b1, lat);
        b_req = 1'b0;
        tot_cnt++; if (lat !== 1 || mem_we !== 1'b0)
            $display("FAIL bw_ack: got lat %0d we %b exp 1 0", lat, mem_we);
        else pass_cnt++;
        @(negedge clk);
        start_a(1'b0, 1'b1, 8'h06, 16'h0);
        wait_ack(1'b0, lat);
        a_req = 1'b0;
        tot_cnt++; if (a_rdata !== 16'hAB34) $display("FAIL bw_readback: got %h exp ab34", a_rdata); else pass_cnt++;
        @(negedge clk);
        // Low lane: byte address 06 replaces [7:0].
        start_b(1'b1, 1'b0, 8'h06, 16'hFF5C);
        wait_ack(1'b1, lat);
        b_req = 1'b0;
        @(negedge clk);
        tot_cnt++; if (mem[3] !== 16'hAB5C) $display("FAIL bw_low_lane: got %h exp ab5c", mem[3]); else pass_cnt++;
    endtask

    task automatic test_contention;
        int   acks = 0;
        int   overlap = 0;
        logic order [4];
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        start_a(1'b0, 1'b1, 8'h10, 16'h0);
        start_b(1'b0, 1'b1, 8'h0A, 16'h0);
        for (int i = 0; i < 20 && acks < 4; i++) begin
            @(negedge clk);
            if (a_ack === 1'b1 && b_ack === 1'b1) overlap++;
            if (a_ack === 1'b1 || b_ack === 1'b1) begin
                order[acks] = b_ack;
                acks++;
            end
        end
        a_req = 1'b0; b_req = 1'b0;
        tot_cnt++; if (acks !== 4) $display("FAIL cont_acks: got %0d exp 4", acks); else pass_cnt++;
        tot_cnt++; if (overlap !== 0) $display("FAIL cont_overlap: got %0d exp 0", overlap); else pass_cnt++;
        tot_cnt++; if (acks == 4 && {order[0], order[1], order[2], order[3]} !== 4'b0101)
            $display("FAIL cont_order: got %b%b%b%b exp 0101 (0=A)", order[0], order[1], order[2], order[3]);
        else pass_cnt++;
        tot_cnt++; if (a_rdata !== 16'hC0DE || b_rdata !== 16'hBEEF)
            $display("FAIL cont_rdata: got %h %h exp c0de beef", a_rdata, b_rdata);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_reset_in_write;
        int lat;
        poke(7'h03, 16'h1234);
        start_b(1'b1, 1'b0, 8'h07, 16'h00CD);
        @(negedge clk);                 // ACCESS
        @(negedge clk);                 // WRITE
        rst_n = 1'b0;
        #1;
        tot_cnt++; if (mem_we !== 1'b0) $display("FAIL rw_mem_we: got %b exp 0", mem_we); else pass_cnt++;
        b_req = 1'b0;
        @(negedge clk);
        tot_cnt++; if (b_ack !== 1'b0 || mem_addr !== 7'h00)
            $display("FAIL rw_idle: got ack %b addr %h exp 0 00", b_ack, mem_addr);
        else pass_cnt++;
        tot_cnt++; if (mem[3] !== 16'h1234) $display("FAIL rw_mem_kept: got %h exp 1234", mem[3]); else pass_cnt++;
        rst_n = 1'b1;
        @(negedge clk);
        tot_cnt++; if (b_ack !== 1'b0) $display("FAIL rw_no_ack: got %b exp 0", b_ack); else pass_cnt++;
        start_a(1'b0, 1'b1, 8'h06, 16'h0);
        wait_ack(1'b0, lat);
        a_req = 1'b0;
        tot_cnt++; if (lat !== 2 || a_rdata !== 16'h1234)
            $display("FAIL rw_recover: got lat %0d data %h exp 2 1234", lat, a_rdata);
        else pass_cnt++;
        @(negedge clk);
    endtask

    task automatic test_back_to_back;
        int lat;
        int w0;
        w0 = we_cnt;
        for (int i = 0; i < 3; i++) begin
            // req stays high through each ack cycle; the next request's
            // fields appear the cycle after.
            start_a(1'b1, 1'b1, 8'(2 * i), 16'(i + 1));
            wait_ack(1'b0, lat);
            tot_cnt++; if (lat !== 2) $display("FAIL b2b_lat%0d: got %0d exp 2", i, lat); else pass_cnt++;
            if (i < 2) @(negedge clk);
        end
        a_req = 1'b0;
        @(negedge clk);
        @(negedge clk);
        tot_cnt++; if (we_cnt - w0 !== 3) $display("FAIL b2b_we_count: got %0d exp 3", we_cnt - w0); else pass_cnt++;
        tot_cnt++; if (mem[0] !== 16'd1 || mem[1] !== 16'd2 || mem[2] !== 16'd3)
            $display("FAIL b2b_mem: got %h %h %h exp 0001 0002 0003", mem[0], mem[1], mem[2]);
        else pass_cnt++;
    endtask

    initial begin
        rst_n = 1'b0;
        a_req = 1'b0; a_we = 1'b0; a_word = 1'b0; a_addr = '0; a_wdata = '0;
        b_req = 1'b0; b_we = 1'b0; b_word = 1'b0; b_addr = '0; b_wdata = '0;
        @(negedge clk);
        poke(7'h05, 16'hBEEF);
        poke(7'h08, 16'hC0DE);
        poke(7'h03, 16'h1234);
        poke(7'h7F, 16'h77AA);
        test_reset;
        test_read;
        test_byte_write;
        test_contention;
        test_reset_in_write;
        test_back_to_back;
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Sequences and shares the single 16-bit-word program/data memory between two requesters.
  - Port A: the CPU data side.
  - Port B: the loader/debug port.
- Converts byte-addressed requests (8-bit byte address, 128 words) into word-wide memory cycles.
- Byte writes are done as a read-modify-write, because the memory only writes whole words.
- Sits between the requesters and the memory macro, which has a combinational read and a write that commits on the clock edge.

Parameters:
- ADDR_W, 8, byte address width; the word address is ADDR_W-1 bits.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  synchronous active-low reset.
- a_req  in  1  port A request; held stable until a_ack.
- a_we  in  1  port A write (1) / read (0).
- a_word  in  1  port A word access (1) / byte access (0).
- a_addr  in  ADDR_W  port A byte address.
- a_wdata  in  16  port A write data; byte writes use [7:0].
- a_ack  out  1  port A completion pulse, one cycle.
- a_rdata  out  16  port A read data, valid while a_ack=1 and held until the next A read completes.
- b_req, b_we, b_word, b_addr, b_wdata, b_ack, b_rdata: same definitions for port B.
- mem_addr  out  ADDR_W-1  word address to memory.
- mem_we  out  1  memory write enable; the write commits at the clock edge.
- mem_wdata  out  16  memory write word.
- mem_rdata  in  16  memory read word for mem_addr, combinational.

Behaviour:
- Interface: one clock; reset is synchronous and active-low.
  - Clock port is clk; reset port is rst_n.
  - Reset is sampled on the clk rising edge only.
- Reset values:
  - State IDLE.
  - a_ack=b_ack=0; a_rdata=b_rdata=0.
  - mem_we=0, mem_addr=0, mem_wdata=0.
  - Round-robin pointer favours A.
  - Latched request registers cleared.
- Reset mid-operation:
  - Any transaction in flight is dropped with no ack.
  - mem_we is gated by rst_n, so no memory write occurs in any cycle where rst_n=0.
  - A byte write reset between its read and write phases leaves memory unchanged.
- FSM states:
  - IDLE: mem_addr=0, mem_we=0.
    - A request is eligible if its req=1 and its ack=0 this cycle. The just-acked requester is ignored in its ack cycle.
    - If only one request is eligible, grant it.
    - If both are eligible, grant the port not granted most recently, then update the pointer.
    - On grant, latch owner, we, word, addr and wdata, and go to ACCESS.
  - ACCESS: mem_addr = latched addr[ADDR_W-1:1].
    - Read: set owner rdata, ack next cycle, go to IDLE.
      - Word read: rdata = mem_rdata.
      - Byte read: rdata = {8'h00, addr[0] ? mem_rdata[15:8] : mem_rdata[7:0]}.
    - Word write: mem_we=1, mem_wdata = latched wdata; ack next cycle; go to IDLE.
    - Byte write: mem_we=0; capture mem_rdata into the merge register; go to WRITE.
  - WRITE: same mem_addr.
    - mem_we=1.
    - mem_wdata = merge register with byte lane addr[0] replaced by wdata[7:0]: lane 0 is [7:0], lane 1 is [15:8].
    - Ack next cycle; go to IDLE.
- Latency, with req sampled in IDLE at cycle 0:
  - Read and word write: memory cycle in cycle 1, ack in cycle 2.
  - Byte write: read in cycle 1, write in cycle 2, ack in cycle 3.
  - The FSM is back in IDLE in the ack cycle, so the other port can be granted in that same cycle.
- Acks are registered one-cycle pulses; a_ack and b_ack are never both 1.
- Word accesses ignore addr[0].
- Address wrap: byte address 8'hFF maps to word 7'h7F, high lane. There is no wrap across words.
- A requester that deasserts req before ack is a protocol violation. The latched request still completes.
- Req, addr and data changes after grant have no effect on the current transaction.

Test Plan:
- Reset behaviour: rst_n=0 for 2 cycles with a_req=1 -> a_ack=0, mem_we=0, mem_addr=0. After release, the A read of addr 8'h10 acks in cycle 2 with mem_addr=7'h08 in cycle 1.
- Word read: memory word 5 = 16'hBEEF; A word read of addr 8'h0A -> a_ack in cycle 2, a_rdata=16'hBEEF. Byte read of addr 8'h0B -> a_rdata=16'h00BE.
- Byte write read-modify-write: word 3 = 16'h1234; B byte write addr 8'h07, wdata 8'hAB -> mem_we only in cycle 2 with mem_wdata=16'hAB34, b_ack in cycle 3. A following word read returns 16'hAB34.
- Contention: a_req and b_req both held high for 4 transactions -> grant order A, B, A, B. Exactly one ack per transaction; acks never overlap.
- Reset during WRITE of a byte write to word 3 (16'h1234) -> mem_we=0 that cycle, no ack, word 3 still 16'h1234. The FSM returns to IDLE.
- Back-to-back: A issues 3 word writes (addr 0, 2, 4; data 1, 2, 3), re-raising req the cycle after each ack -> words 0..2 = 1, 2, 3. No transaction is duplicated because the req in the ack cycle is ignored.
